// File: rtl/lfsr_sched_if.sv
// rtl/lfsr_sched_if.sv - register-write bus between the scheduler and the LFSR block
interface lfsr_sched_if #(
    parameter int N = 8
);
    logic [15:0]  lfsr_A;
    logic         lfsr_W;
    logic [N-1:0] lfsr_D;
    logic [N-1:0] lfsr_Q;

    modport master (
        output lfsr_A,
        output lfsr_W,
        output lfsr_D,
        input  lfsr_Q
    );

    modport slave (
        input  lfsr_A,
        input  lfsr_W,
        input  lfsr_D,
        output lfsr_Q
    );
endinterface

// File: rtl/lfsr_sched.sv
// rtl/lfsr_sched.sv - round-robin LFSR step scheduler with configure sequencer
module lfsr_sched #(
    parameter int          N         = 8,
    parameter int          NREQ      = 4,
    parameter int          WAIT_CYC  = 2,
    parameter logic [15:0] POLY_ADDR = 16'h0012,
    parameter logic [15:0] SEED_ADDR = 16'h0014,
    parameter logic [15:0] CTRL_ADDR = 16'h0010
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cfg_start,
    input  logic [N-1:0]    cfg_poly,
    input  logic [N-1:0]    cfg_seed,
    output logic            cfg_busy,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] rnd_valid,
    output logic [N-1:0]    rnd_data,
    output logic            busy,
    lfsr_sched_if.master    bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] S_UNCFG   = 3'd0;
    localparam logic [2:0] S_WR_POLY = 3'd1;
    localparam logic [2:0] S_WR_SEED = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_STEP    = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_STOP    = 3'd6;
    localparam logic [2:0] S_DELIVER = 3'd7;

    // WAIT is left when the counter reaches zero, so it is loaded with one less.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);

    logic [2:0]      state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            pend_q, pend_d;
    logic [N-1:0]    poly_q, poly_d;
    logic [N-1:0]    seed_q, seed_d;

    logic            cfg_busy_q, cfg_busy_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] rnd_valid_q, rnd_valid_d;
    logic [N-1:0]    rnd_data_q, rnd_data_d;
    logic [15:0]     bus_a_q, bus_a_d;
    logic            bus_w_q, bus_w_d;
    logic [N-1:0]    bus_wd_q, bus_wd_d;

    logic            accept;
    logic            in_grant;
    logic            rr_hit;
    logic [GW-1:0]   rr_pick;
    logic [GW-1:0]   rr_idx;

    // A configure command is only taken while nothing is pending or being written.
    assign accept   = cfg_start & ~cfg_busy_q;
    assign in_grant = (state_q == S_STEP) || (state_q == S_WAIT) ||
                      (state_q == S_STOP) || (state_q == S_DELIVER);

    // Round-robin search: scan downwards so the requester closest to rr wins.
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = '0;
        rr_idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_idx = GW'((int'(rr_q) + k) % NREQ);
            if (req[rr_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = rr_idx;
            end
        end
    end

    // Sequencer next state, configure capture and pending-configure tracking.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        pend_d  = pend_q;
        poly_d  = poly_q;
        seed_d  = seed_q;

        if (accept) begin
            poly_d = cfg_poly;
            seed_d = cfg_seed;
        end

        // A configure arriving mid-transaction is parked until the next READY.
        if (accept && in_grant) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_UNCFG: begin
                if (accept) begin
                    state_d = S_WR_POLY;
                end
            end
            S_WR_POLY: begin
                state_d = S_WR_SEED;
            end
            S_WR_SEED: begin
                state_d = S_READY;
            end
            S_READY: begin
                if (pend_q || accept) begin
                    state_d = S_WR_POLY;
                    pend_d  = 1'b0;
                end else if (rr_hit) begin
                    grant_d = rr_pick;
                    rr_d    = GW'((int'(rr_pick) + 1) % NREQ);
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                wcnt_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_STOP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_STOP: begin
                state_d = S_DELIVER;
            end
            S_DELIVER: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_UNCFG;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they can be registered.
    always_comb begin
        bus_a_d  = 16'h0000;
        bus_w_d  = 1'b0;
        bus_wd_d = '0;
        case (state_d)
            S_WR_POLY: begin
                bus_a_d  = POLY_ADDR;
                bus_w_d  = 1'b1;
                bus_wd_d = poly_d;
            end
            S_WR_SEED: begin
                bus_a_d  = SEED_ADDR;
                bus_w_d  = 1'b1;
                bus_wd_d = seed_d;
            end
            S_STEP: begin
                bus_a_d  = CTRL_ADDR;
                bus_w_d  = 1'b1;
                bus_wd_d = N'(1);
            end
            S_STOP: begin
                bus_a_d  = CTRL_ADDR;
                bus_w_d  = 1'b1;
                bus_wd_d = '0;
            end
            default: begin
            end
        endcase

        busy_d     = (state_d == S_STEP) || (state_d == S_WAIT) ||
                     (state_d == S_STOP) || (state_d == S_DELIVER);
        cfg_busy_d = (state_d == S_WR_POLY) || (state_d == S_WR_SEED) || pend_d;

        rnd_valid_d = '0;
        if (state_d == S_DELIVER) begin
            rnd_valid_d[grant_d] = 1'b1;
        end

        // The stepped value has settled by STOP; hold it for the delivery cycle.
        rnd_data_d = (state_q == S_STOP) ? bus.lfsr_Q : rnd_data_q;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_UNCFG;
            wcnt_q      <= 4'd0;
            rr_q        <= '0;
            grant_q     <= '0;
            pend_q      <= 1'b0;
            poly_q      <= '0;
            seed_q      <= '0;
            cfg_busy_q  <= 1'b0;
            busy_q      <= 1'b0;
            rnd_valid_q <= '0;
            rnd_data_q  <= '0;
            bus_a_q     <= 16'h0000;
            bus_w_q     <= 1'b0;
            bus_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            pend_q      <= pend_d;
            poly_q      <= poly_d;
            seed_q      <= seed_d;
            cfg_busy_q  <= cfg_busy_d;
            busy_q      <= busy_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            bus_a_q     <= bus_a_d;
            bus_w_q     <= bus_w_d;
            bus_wd_q    <= bus_wd_d;
        end
    end

    assign cfg_busy   = cfg_busy_q;
    assign busy       = busy_q;
    assign rnd_valid  = rnd_valid_q;
    assign rnd_data   = rnd_data_q;
    assign bus.lfsr_A = bus_a_q;
    assign bus.lfsr_W = bus_w_q;
    assign bus.lfsr_D = bus_wd_q;

endmodule
